// File: rtl/cla_pkg.sv
// Shared constants, state encoding and a width helper for the nibble-serial subtractor.
// Optional feature macro used by the top: OVERFLOW_FLAG_EN.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Bits needed to count 0..value-1; callers guarantee value >= 2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_borrow_slice4.sv
// Combinational 4-bit lookahead-borrow subtractor: {bo, d} = x - y - bi.
module cla_borrow_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] b;

  // A bit generates a borrow when x=0,y=1 and passes the incoming borrow when x==y.
  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign b[0] = bi;
  assign b[1] = g[0] | (p[0] & bi);
  assign b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
  assign bo   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d = x ^ y ^ b;

endmodule

// File: rtl/cla_serial_subtractor.sv
// Nibble-serial WIDTH-bit subtractor, diff = a - b - bin, with valid/ready on both sides.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module cla_serial_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int CW  = clog2(NIB);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [SLICE_W-1:0] slice_d;
  logic             slice_bo;

`ifdef OVERFLOW_FLAG_EN
  logic a_msb;
  logic b_msb;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  cla_borrow_slice4 u_slice (
    .x  (a_sh[SLICE_W-1:0]),
    .y  (b_sh[SLICE_W-1:0]),
    .bi (borrow),
    .d  (slice_d),
    .bo (slice_bo)
  );

  // Each RUN edge consumes the low nibble of a/b and pushes its result in at the top of diff,
  // so after NIB edges the first nibble computed has reached the bottom.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= RUN;
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            count  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            ovf    <= 1'b0;
`endif
          end
        end
        RUN: begin
          diff   <= {slice_d, diff[WIDTH-1:SLICE_W]};
          a_sh   <= {{SLICE_W{1'b0}}, a_sh[WIDTH-1:SLICE_W]};
          b_sh   <= {{SLICE_W{1'b0}}, b_sh[WIDTH-1:SLICE_W]};
          borrow <= slice_bo;
          count  <= count + CW'(1);
          if (count == CW'(NIB - 1)) begin
            state <= DONE;
            bout  <= slice_bo;
`ifdef OVERFLOW_FLAG_EN
            // The last slice's top bit is the sign of the finished difference.
            ovf   <= (a_msb != b_msb) && (slice_d[SLICE_W-1] != a_msb);
`endif
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
